booth_wallace_mult: RTL and testbench

//  Signed two's-complement multiplier: radix-4 Booth partial-product generation, Wallace (3:2 CSA) reduction, final CPA.

---
 rtl/booth_wallace_mult_pkg.sv | 45 ++++
 rtl/booth_wallace_mult_pp.sv | 37 +++
 rtl/booth_wallace_mult.sv | 134 +++++++++++++
 tb/tb_booth_wallace_mult.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/booth_wallace_mult_pkg.sv
// Shared constants, Booth recoding and CSA-tree sizing helpers for booth_wallace_mult.
// Optional macro BOOTH_WALLACE_PIPE_EN (used by the top) adds a register ahead of the final adder.
package booth_wallace_mult_pkg;

  localparam int WIDTH_DATA = 16;
  localparam int PP_COUNT   = WIDTH_DATA / 2;
  localparam int PROD_W     = 2 * WIDTH_DATA;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG2, NEG1} booth_code_e;

  function automatic booth_code_e booth_decode(input logic [2:0] grp);
    booth_code_e code;
    case (grp)
      3'b001, 3'b010: code = POS1;
      3'b011:         code = POS2;
      3'b100:         code = NEG2;
      3'b101, 3'b110: code = NEG1;
      default:        code = ZERO;
    endcase
    return code;
  endfunction

  // Each 3:2 level turns every full group of three rows into two; leftovers pass through.
  function automatic int csa_rows_at(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++) begin
      if (n > 2) n = (n / 3) * 2 + (n % 3);
    end
    return n;
  endfunction

  function automatic int csa_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = (n / 3) * 2 + (n % 3);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/booth_wallace_mult_pp.sv
// Radix-4 Booth partial-product cell: one recoded group selects 0, +/-W or +/-2W of the multiplicand.
// Negative selections are emitted as one's complement; the +1 leaves through neg for the tree to absorb.
module booth_r4_pp
  import booth_wallace_mult_pkg::*;
#(
  parameter int W = WIDTH_DATA
) (
  input  logic [2:0]     grp,
  input  logic [W-1:0]   mcand,
  output logic [2*W-1:0] pp,
  output logic           neg
);

  booth_code_e    code;
  logic [2*W-1:0] ext;

  always_comb begin
    code = booth_decode(grp);
    ext  = {{W{mcand[W-1]}}, mcand};
    pp   = '0;
    neg  = 1'b0;
    case (code)
      POS1: pp = ext;
      POS2: pp = ext << 1;
      NEG1: begin
        pp  = ~ext;
        neg = 1'b1;
      end
      NEG2: begin
        pp  = ~(ext << 1);
        neg = 1'b1;
      end
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_wallace_mult.sv
// Signed multiplier: radix-4 Booth PPs, Wallace 3:2 reduction, one carry-propagate add, registered out.
// Define BOOTH_WALLACE_PIPE_EN to register the sum/carry vectors before the CPA (latency 2 instead of 1).
module booth_wallace_mult
  import booth_wallace_mult_pkg::*;
#(
  parameter int W = WIDTH_DATA
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   weight,
  input  logic [W-1:0]   feature,
  output logic           out_valid,
  output logic [2*W-1:0] result_out
);

  localparam int NPP  = W / 2;
  localparam int PW   = 2 * W;
  localparam int NOPS = NPP + 1;
  localparam int NLVL = csa_levels(NOPS);

  logic [W:0]    fext;
  logic [PW-1:0] pp [NPP];
  logic [NPP-1:0] neg;
  logic [PW-1:0] corr;

  assign fext = {feature, 1'b0};

  for (genvar g = 0; g < NPP; g++) begin : g_pp
    booth_r4_pp #(.W(W)) u_pp (
      .grp  (fext[2*g+2 -: 3]),
      .mcand(weight),
      .pp   (pp[g]),
      .neg  (neg[g])
    );
  end

  // Correction columns 2g never collide, so all +1s share a single tree operand.
  always_comb begin
    corr = '0;
    for (int g = 0; g < NPP; g++) corr[2*g] = neg[g];
  end

  for (genvar l = 0; l <= NLVL; l++) begin : g_lvl
    localparam int N = csa_rows_at(NOPS, l);
    logic [PW-1:0] rows [N];
    if (l == 0) begin : g_init
      for (genvar r = 0; r < NPP; r++) begin : g_row
        assign rows[r] = pp[r] << (2 * r);
      end
      assign rows[NPP] = corr;
    end else begin : g_csa
      localparam int NP = csa_rows_at(NOPS, l - 1);
      localparam int NG = NP / 3;
      for (genvar r = 0; r < N; r++) begin : g_row
        if (r < 2 * NG) begin : g_add
          localparam int B = 3 * (r / 2);
          if (r % 2 == 0) begin : g_sum
            assign rows[r] = g_lvl[l-1].rows[B] ^ g_lvl[l-1].rows[B+1] ^ g_lvl[l-1].rows[B+2];
          end else begin : g_cry
            assign rows[r] = ((g_lvl[l-1].rows[B]   & g_lvl[l-1].rows[B+1]) |
                              (g_lvl[l-1].rows[B]   & g_lvl[l-1].rows[B+2]) |
                              (g_lvl[l-1].rows[B+1] & g_lvl[l-1].rows[B+2])) << 1;
          end
        end else begin : g_pass
          assign rows[r] = g_lvl[l-1].rows[3*NG + r - 2*NG];
        end
      end
    end
  end

  logic [PW-1:0] tree_sum;
  logic [PW-1:0] tree_carry;
  logic [PW-1:0] cpa_a;
  logic [PW-1:0] cpa_b;
  logic          cpa_vld;
  logic [PW-1:0] result_d, result_q;
  logic          out_valid_d, out_valid_q;

  assign tree_sum   = g_lvl[NLVL].rows[0];
  assign tree_carry = g_lvl[NLVL].rows[1];

`ifdef BOOTH_WALLACE_PIPE_EN
  logic [PW-1:0] sum_d, sum_q;
  logic [PW-1:0] carry_d, carry_q;
  logic          s1_vld_d, s1_vld_q;

  always_comb begin
    s1_vld_d = in_valid;
    sum_d    = in_valid ? tree_sum   : sum_q;
    carry_d  = in_valid ? tree_carry : carry_q;
    cpa_a    = sum_q;
    cpa_b    = carry_q;
    cpa_vld  = s1_vld_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      carry_q  <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      s1_vld_q <= s1_vld_d;
    end
  end
`else
  always_comb begin
    cpa_a   = tree_sum;
    cpa_b   = tree_carry;
    cpa_vld = in_valid;
  end
`endif

  always_comb begin
    out_valid_d = cpa_vld;
    result_d    = cpa_vld ? cpa_a + cpa_b : result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result_out = result_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_booth_wallace_mult.sv
// Bench for booth_wallace_mult: directed corners, random streams vs a $signed product model, async reset.
module tb_booth_wallace_mult;

`ifdef BOOTH_WALLACE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] weight;
  logic [15:0] feature;
  logic        out_valid;
  logic [31:0] result_out;

  int          cyc;
  int          checks;
  int          errors;
  logic [31:0] held;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  booth_wallace_mult #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .weight    (weight),
    .feature   (feature),
    .out_valid (out_valid),
    .result_out(result_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] w, input logic [15:0] f);
    logic signed [31:0] p;
    p = $signed(w) * $signed(f);
    return p;
  endfunction

  // driver
  task automatic drive(input logic v, input logic [15:0] w, input logic [15:0] f,
                       input logic [31:0] e);
    @(posedge clk);
    #1;
    in_valid = v;
    weight   = w;
    feature  = f;
    if (v) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + LAT);
    end
  endtask

  task automatic drive_rand(input logic v);
    logic [15:0] w;
    logic [15:0] f;
    w = 16'($urandom_range(0, 65535));
    f = 16'($urandom_range(0, 65535));
    drive(v, w, f, model(w, f));
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        chk("out_valid_hi", 64'(out_valid), 64'd1);
        chk("product", 64'(result_out), 64'(exp_q[0]));
        held = exp_q[0];
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        chk("out_valid_lo", 64'(out_valid), 64'd0);
        chk("hold", 64'(result_out), 64'(held));
      end
    end
  end

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    held     = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    weight   = '0;
    feature  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result_out), 64'd0);
    rst_n = 1'b1;

    drive(1'b1, 16'd6, 16'd13, 32'd78);
    drive(1'b0, 16'h1234, 16'h5678, 32'd0);
    drive(1'b0, 16'h0bad, 16'h0f0f, 32'd0);
    drive(1'b1, 16'hffff, 16'hffff, 32'd1);
    drive(1'b1, 16'hfff9, 16'd5, 32'hffff_ffdd);
    drive(1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
    drive(1'b1, 16'h7fff, 16'h8000, 32'hc000_8000);
    drive(1'b1, 16'd0, 16'd12345, 32'd0);
    repeat (4) drive(1'b0, 16'h7fff, 16'h7fff, 32'd0);

    for (int i = 0; i < 1000; i++) drive_rand(1'b1);
    for (int i = 0; i < 200; i++) drive_rand($urandom_range(0, 2) != 0);

    for (int i = 0; i < 20; i++) drive_rand(1'b1);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_result", 64'(result_out), 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    held = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 16'h1111, 16'h2222, 32'd0);
    drive(1'b0, 16'h3333, 16'h4444, 32'd0);
    for (int i = 0; i < 100; i++) drive_rand(1'b1);
    drive(1'b0, 16'h0000, 16'h0000, 32'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
